// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings and the
// receive FSM state type.
package uart_pkg;

    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Codes 00 and 11 both mean the frame carries no parity bit.
    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high serial line does not look like a start bit.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive front end: synchronises the line, finds the start bit, samples
// each bit at mid-bit from a 16x tick and publishes the deserialised frame.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic                  baud_tick,
    input  logic [1:0]            parity_type,
    output logic [DATA_WIDTH-1:0] raw_data,
    output logic                  start_bit,
    output logic                  parity_bit,
    output logic                  stop_bit,
    output logic                  recieved_flag,
    output logic                  rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    logic rx_s;

    uart_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (rx_in),
        .q_o     (rx_s)
    );

    rx_state_e             state_q;
    logic                  armed_q;
    logic [TW-1:0]         tick_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [1:0]            ptype_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  start_smp_q;
    logic                  par_smp_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] raw_data_q;
    logic                  start_bit_q;
    logic                  parity_bit_q;
    logic                  stop_bit_q;
    logic                  flag_q;
    logic                  busy_q;

    logic at_half;
    logic at_full;

    assign at_half = (tick_cnt_q == TICK_HALF);
    assign at_full = (tick_cnt_q == TICK_FULL);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            ptype_q      <= 2'b00;
            // NOTE: the shift register is a handful of flops, not a RAM, so it is
            // reset along with everything else and never leaks stale data.
            shift_q      <= '0;
            start_smp_q  <= 1'b0;
            par_smp_q    <= 1'b1;
            done_q       <= 1'b0;
            raw_data_q   <= '0;
            start_bit_q  <= 1'b0;
            parity_bit_q <= 1'b1;
            stop_bit_q   <= 1'b1;
            flag_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low every clock so it can only ever be a
            // single-cycle pulse; only the hand-off branch below raises it.
            flag_q <= 1'b0;

            if (done_q) begin
                // One clock after the stop sample: strobe, release busy and
                // disarm so a line still held low cannot start a new frame.
                done_q  <= 1'b0;
                flag_q  <= 1'b1;
                busy_q  <= 1'b0;
                armed_q <= 1'b0;
                state_q <= IDLE;
            end else if (baud_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                            ptype_q    <= parity_type;
                            busy_q     <= 1'b1;
                        end
                    end

                    START: begin
                        if (at_half) begin
                            if (rx_s) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                start_smp_q <= rx_s;
                                tick_cnt_q  <= '0;
                                bit_cnt_q   <= '0;
                                state_q     <= DATA;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end

                    DATA: begin
                        // The counter wraps from OVERSAMPLE-1 to 0 on its own,
                        // so each wrap lands exactly one bit period later.
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (at_full) begin
                            shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                par_smp_q <= 1'b1;
                                state_q   <= parity_enabled(ptype_q) ? PARITY : STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end

                    PARITY: begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (at_full) begin
                            par_smp_q <= rx_s;
                            state_q   <= STOP;
                        end
                    end

                    STOP: begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (at_full) begin
                            raw_data_q   <= shift_q;
                            start_bit_q  <= start_smp_q;
                            parity_bit_q <= par_smp_q;
                            stop_bit_q   <= rx_s;
                            done_q       <= 1'b1;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign raw_data      = raw_data_q;
    assign start_bit     = start_bit_q;
    assign parity_bit    = parity_bit_q;
    assign stop_bit      = stop_bit_q;
    assign recieved_flag = flag_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: table of frames plus hand-written sequences
// for glitch, framing error with held-low line, mid-frame reset and back-to-back.
module tb_uart_rx_sipo;
    import uart_pkg::*;

    localparam int DW        = 8;
    localparam int OS        = 16;
    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = OS * TICK_CLKS;

    logic          clock       = 1'b0;
    logic          reset_n     = 1'b0;
    logic          rx_in       = 1'b1;
    logic          baud_tick   = 1'b0;
    logic [1:0]    parity_type = 2'b00;
    logic [DW-1:0] raw_data;
    logic          start_bit;
    logic          parity_bit;
    logic          stop_bit;
    logic          recieved_flag;
    logic          rx_busy;

    uart_rx_sipo #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_in         (rx_in),
        .baud_tick     (baud_tick),
        .parity_type   (parity_type),
        .raw_data      (raw_data),
        .start_bit     (start_bit),
        .parity_bit    (parity_bit),
        .stop_bit      (stop_bit),
        .recieved_flag (recieved_flag),
        .rx_busy       (rx_busy)
    );

    always #5 clock = ~clock;

    // One-clock tick every TICK_CLKS clocks.
    initial begin
        forever begin
            repeat (TICK_CLKS - 1) @(posedge clock);
            #1 baud_tick = 1'b1;
            @(posedge clock);
            #1 baud_tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       par;
        logic       stop;
        int         cyc;
    } cap_t;

    cap_t        caps[$];
    logic        flag_prev   = 1'b0;
    int          flag_long   = 0;
    int          chg         = 0;
    logic [10:0] fields_prev = 11'b00000000_0_1_1;

    always @(negedge clock) begin
        if (recieved_flag) caps.push_back('{raw_data, start_bit, parity_bit, stop_bit, cyc});
        if (recieved_flag && flag_prev) flag_long <= flag_long + 1;
        flag_prev <= recieved_flag;
        if ({raw_data, start_bit, parity_bit, stop_bit} != fields_prev) chg <= chg + 1;
        fields_prev <= {raw_data, start_bit, parity_bit, stop_bit};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Error-check stage model: {start error, parity error, stop error}.
    function automatic logic [2:0] err_of(input cap_t c, input logic [1:0] pt);
        logic perr;
        perr = 1'b0;
        if (pt == PARITY_EVEN)     perr = ^{c.data, c.par};
        else if (pt == PARITY_ODD) perr = ~^{c.data, c.par};
        return {c.start, perr, ~c.stop};
    endfunction

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(posedge clock);
        #1;
    endtask

    // scramble flips parity_type to the other category right after the start bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic par,
                              input logic stop, input bit scramble, output int t0);
        parity_type = pt;
        t0 = cyc;
        send_bit(1'b0);
        if (scramble) parity_type = parity_enabled(pt) ? 2'b00 : PARITY_EVEN;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (parity_enabled(pt)) send_bit(par);
        send_bit(stop);
    endtask

    task automatic wait_caps(input int n, input int max_clks, input string name);
        int k;
        k = 0;
        while (caps.size() < n && k < max_clks) begin
            @(negedge clock);
            k++;
        end
        check(name, caps.size(), n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] ptype;
        logic       par;
        logic       stop;
        bit         scramble;
        logic [7:0] exp_data;
        logic       exp_par;
        logic       exp_stop;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   t0;
        int   lat;
        int   exp_lat;
        int   chg0;
        int   k;
        bit   busy_seen;
        cap_t c;

        vecs[0] = '{8'hA5, 2'b10, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 3'b000};
        vecs[1] = '{8'h3C, 2'b00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 3'b000};
        vecs[2] = '{8'h80, 2'b01, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 3'b000};
        vecs[3] = '{8'h00, 2'b01, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'b000};
        vecs[4] = '{8'h7E, 2'b11, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 3'b000};
        vecs[5] = '{8'hFF, 2'b10, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 3'b000};
        vecs[6] = '{8'hC3, 2'b10, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 3'b010};

        repeat (5) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_raw_data", raw_data, 8'h00);
        check("rst_start_bit", start_bit, 1'b0);
        check("rst_parity_bit", parity_bit, 1'b1);
        check("rst_stop_bit", stop_bit, 1'b1);
        check("rst_flag", recieved_flag, 1'b0);
        check("rst_busy", rx_busy, 1'b0);

        @(posedge clock);
        #1;
        send_bit(1'b1);

        for (int i = 0; i < 7; i++) begin
            caps.delete();
            send_frame(vecs[i].data, vecs[i].ptype, vecs[i].par, vecs[i].stop, vecs[i].scramble, t0);
            send_bit(1'b1);
            wait_caps(1, 200, $sformatf("v%0d_flag_count", i));
            if (caps.size() > 0) begin
                c = caps[0];
                check($sformatf("v%0d_data", i), c.data, vecs[i].exp_data);
                check($sformatf("v%0d_start", i), c.start, 1'b0);
                check($sformatf("v%0d_parity", i), c.par, vecs[i].exp_par);
                check($sformatf("v%0d_stop", i), c.stop, vecs[i].exp_stop);
                check($sformatf("v%0d_err", i), err_of(c, vecs[i].ptype), vecs[i].exp_err);
                // Stop mid-bit plus sync, tick-quantised detect and flag delay.
                exp_lat = (parity_enabled(vecs[i].ptype) ? 10 : 9) * BIT_CLKS + BIT_CLKS / 2 + 5;
                lat = c.cyc - t0;
                check($sformatf("v%0d_latency_%0d", i, lat),
                      (lat >= exp_lat - TICK_CLKS) && (lat <= exp_lat + TICK_CLKS), 1'b1);
            end
        end

        // Short low glitch on an idle line.
        caps.delete();
        busy_seen = 1'b0;
        rx_in = 1'b0;
        repeat (4 * TICK_CLKS) begin
            @(negedge clock);
            if (rx_busy) busy_seen = 1'b1;
        end
        rx_in = 1'b1;
        k = 0;
        while (rx_busy && k < 8 * TICK_CLKS) begin
            @(negedge clock);
            k++;
        end
        check("glitch_busy_rose", busy_seen, 1'b1);
        check("glitch_busy_fell", rx_busy, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("glitch_no_flag", caps.size(), 0);

        // Framing error followed by a line held low for three frame times.
        caps.delete();
        send_frame(8'h01, PARITY_ODD, 1'b0, 1'b0, 1'b0, t0);
        repeat (3 * 11 * BIT_CLKS) @(posedge clock);
        #1;
        check("brk_flag_count", caps.size(), 1);
        if (caps.size() > 0) begin
            c = caps[0];
            check("brk_data", c.data, 8'h01);
            check("brk_stop", c.stop, 1'b0);
            check("brk_parity", c.par, 1'b0);
            check("brk_err", err_of(c, PARITY_ODD), 3'b001);
        end
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clock);
        #1;
        check("brk_no_extra_flag", caps.size(), 1);
        check("brk_busy", rx_busy, 1'b0);

        // Reset in the middle of data bit 4 of 0xFF.
        caps.delete();
        parity_type = 2'b00;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (BIT_CLKS / 2) @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("mrst_raw_data", raw_data, 8'h00);
        check("mrst_parity_bit", parity_bit, 1'b1);
        check("mrst_stop_bit", stop_bit, 1'b1);
        check("mrst_busy", rx_busy, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mrst_no_flag", caps.size(), 0);
        send_frame(8'h12, 2'b00, 1'b1, 1'b1, 1'b0, t0);
        send_bit(1'b1);
        wait_caps(1, 200, "mrst_flag_count");
        if (caps.size() > 0) begin
            check("mrst_data", caps[0].data, 8'h12);
            check("mrst_parity", caps[0].par, 1'b1);
        end

        // Back-to-back frames with a single stop bit and no idle gap.
        caps.delete();
        chg0 = chg;
        send_frame(8'h55, PARITY_EVEN, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'hAA, PARITY_EVEN, 1'b0, 1'b1, 1'b0, t0);
        send_bit(1'b1);
        wait_caps(2, 200, "b2b_flag_count");
        if (caps.size() > 1) begin
            check("b2b_data0", caps[0].data, 8'h55);
            check("b2b_data1", caps[1].data, 8'hAA);
            check("b2b_err0", err_of(caps[0], PARITY_EVEN), 3'b000);
            check("b2b_err1", err_of(caps[1], PARITY_EVEN), 3'b000);
        end
        check("b2b_output_changes", chg - chg0, 2);
        check("flag_single_cycle", flag_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
